// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame controller.
// Register map geometry and write-strobe helpers.
package spi_pkg;

  localparam int ADDR_W        = 7;
  localparam int CMD_WRITE_BIT = 7;

  localparam logic [ADDR_W-1:0] NUM_REGS  = ADDR_W'(60);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(59);
  localparam logic [ADDR_W-1:0] WR_FIRST  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WR_LAST   = ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA
  } ctrl_state_t;

  function automatic logic in_wr_range(
    input logic [ADDR_W-1:0] a
  );
    return (a >= WR_FIRST) && (a <= WR_LAST);
  endfunction

  function automatic logic [2:0] onehot_wr(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] d;
    d = a - WR_FIRST;
    return 3'b001 << d[1:0];
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// MSB-first byte deserialiser with bit counter.
// done is combinational on the completing edge; byte_done follows it.
module spi_byte_shifter (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       en,
  input  logic       din,
  output logic [7:0] byte_val,
  output logic       done,
  output logic       byte_done
);

  logic [6:0] sr;
  logic [2:0] bit_cnt;

  assign done     = en && (bit_cnt == 3'd7);
  assign byte_val = {sr, din};

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      sr        <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else if (en) begin
      sr        <= {sr[5:0], din};
      bit_cnt   <= bit_cnt + 3'd1;
      byte_done <= done;
    end else begin
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer: command decode, write strobes and
// MSB-first register readout for the special-register SPI port.
module spi_frame_ctrl
  import spi_pkg::*;
(
  input  logic              sclk,
  input  logic              rstn,
  input  logic              frame_active,
  input  logic              serial_in,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        write_data,
  output logic [2:0]        wr_strobe,
  output logic              serial_out,
  output logic              byte_done,
  output logic              frame_err
);

  ctrl_state_t       state, state_n;
  logic [ADDR_W-1:0] addr_n, addr_inc;
  logic [7:0]        write_data_n, byte_val;
  logic [7:0]        rsr, rsr_n;
  logic [2:0]        wr_strobe_n;
  logic              frame_err_n, inc_err;
  logic              load_pending, load_pending_n;
  logic              done;

  spi_byte_shifter u_shift (
    .sclk      (sclk),
    .rstn      (rstn),
    .en        (frame_active),
    .din       (serial_in),
    .byte_val  (byte_val),
    .done      (done),
    .byte_done (byte_done)
  );

  always_comb begin
    addr_inc = addr + ADDR_W'(1);
    inc_err  = 1'b0;
    if (addr == LAST_ADDR) begin
      addr_inc = '0;
      inc_err  = 1'b1;
    end
  end

  always_comb begin
    state_n        = state;
    addr_n         = addr;
    write_data_n   = write_data;
    wr_strobe_n    = '0;
    frame_err_n    = frame_err;
    load_pending_n = 1'b0;
    rsr_n          = {rsr[6:0], 1'b0};
    if (load_pending)
      rsr_n = {rd_data[6:0], 1'b0};
    if (!frame_active) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_n     = CMD;
          frame_err_n = 1'b0;
        end
        CMD: if (done) begin
          addr_n = byte_val[ADDR_W-1:0];
          if (byte_val[ADDR_W-1:0] >= NUM_REGS)
            frame_err_n = 1'b1;
          if (byte_val[CMD_WRITE_BIT]) begin
            state_n = WDATA;
          end else begin
            state_n        = RDATA;
            load_pending_n = 1'b1;
          end
        end
        WDATA: if (done) begin
          write_data_n = byte_val;
          addr_n       = addr_inc;
          if (in_wr_range(addr))
            wr_strobe_n = onehot_wr(addr);
          else
            frame_err_n = 1'b1;
          if (inc_err)
            frame_err_n = 1'b1;
        end
        RDATA: if (done) begin
          addr_n         = addr_inc;
          load_pending_n = 1'b1;
          if (inc_err)
            frame_err_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      addr         <= '0;
      write_data   <= '0;
      wr_strobe    <= '0;
      frame_err    <= 1'b0;
      load_pending <= 1'b0;
      rsr          <= '0;
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      write_data   <= write_data_n;
      wr_strobe    <= wr_strobe_n;
      frame_err    <= frame_err_n;
      load_pending <= load_pending_n;
      rsr          <= rsr_n;
    end
  end

  // First bit of a read byte comes straight from the mux.
  assign serial_out = (state == RDATA) &&
                      (load_pending ? rd_data[7] : rsr[7]);

endmodule
